// File: rtl/d_e_pipe_reg_pkg.sv
// Shared widths and encodings for the D/E pipeline register.
package d_e_pipe_reg_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned TW_DEF = 2;

  // sll $0,$0,0 doubles as the bubble instruction word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [TW_DEF-1:0] TNEW_ALU  = TW_DEF'(1);
  localparam logic [TW_DEF-1:0] TNEW_LOAD = TW_DEF'(2);

endpackage

// File: rtl/d_e_pipe_reg_pipe_field.sv
// One pipeline field: async-reset register with hold (freeze) and clear (bubble).
module pipe_field #(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // hold has priority over clear
  always_comb begin
    q_d = q_q;
    if (!hold) begin
      if (clr) q_d = CLR_VAL;
      else     q_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/d_e_pipe_reg.sv
// D/E pipeline register: captures D-stage results for E, inserts bubbles on
// stall/flush, freezes on E hold, and pre-decrements Tnew for the hazard unit.
module d_e_pipe_reg
  import d_e_pipe_reg_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_D,
  input  logic          flush_D,
  input  logic          hold_E,
  input  logic [DW-1:0] D_PC,
  input  logic [DW-1:0] D_Instr,
  input  logic [DW-1:0] D_RD1,
  input  logic [DW-1:0] D_RD2,
  input  logic [DW-1:0] D_ExtImm,
  input  logic [AW-1:0] D_A3,
  input  logic [TW-1:0] D_Tnew,
  output logic [DW-1:0] E_PC,
  output logic [DW-1:0] E_Instr,
  output logic [DW-1:0] E_RD1,
  output logic [DW-1:0] E_RD2,
  output logic [DW-1:0] E_ExtImm,
  output logic [AW-1:0] E_A3,
  output logic [TW-1:0] E_Tnew,
  output logic          E_valid
);

  logic          bubble_c;
  logic [TW-1:0] tnew_q;
  logic [TW-1:0] tnew_d;
  logic          valid_q;
  logic          valid_d;

  assign bubble_c = stall_D | flush_D;

  // PC survives a bubble so EPC stays meaningful
  pipe_field #(.W(DW)) u_pc (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(1'b0), .d(D_PC), .q(E_PC)
  );

  pipe_field #(.W(DW), .CLR_VAL(DW'(NOP_INSTR))) u_instr (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(bubble_c), .d(D_Instr), .q(E_Instr)
  );

  pipe_field #(.W(DW)) u_rd1 (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(bubble_c), .d(D_RD1), .q(E_RD1)
  );

  pipe_field #(.W(DW)) u_rd2 (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(bubble_c), .d(D_RD2), .q(E_RD2)
  );

  pipe_field #(.W(DW)) u_ext_imm (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(bubble_c), .d(D_ExtImm), .q(E_ExtImm)
  );

  pipe_field #(.W(AW)) u_a3 (
    .clk(clk), .reset(reset), .hold(hold_E), .clr(bubble_c), .d(D_A3), .q(E_A3)
  );

  // Tnew saturates at 0; a $0 destination never produces a hazard
  always_comb begin
    tnew_d  = tnew_q;
    valid_d = valid_q;
    if (!hold_E) begin
      if (bubble_c) begin
        tnew_d  = '0;
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        if ((D_A3 == '0) || (D_Tnew == '0)) tnew_d = '0;
        else                                tnew_d = D_Tnew - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tnew_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
    end
  end

  assign E_Tnew  = tnew_q;
  assign E_valid = valid_q;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Scoreboard bench for d_e_pipe_reg: directed vectors push expected E-stage
// contents; a monitor pops and compares one entry after each rising edge.
module tb_d_e_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        valid;
  } e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_D, flush_D, hold_E;
  logic [31:0] D_PC, D_Instr, D_RD1, D_RD2, D_ExtImm;
  logic [4:0]  D_A3;
  logic [1:0]  D_Tnew;
  logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_ExtImm;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;
  logic        E_valid;

  int checks   = 0;
  int failures = 0;
  e_t exp_q[$];

  always #5 clk = ~clk;

  d_e_pipe_reg dut (
    .clk(clk), .reset(reset),
    .stall_D(stall_D), .flush_D(flush_D), .hold_E(hold_E),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .D_ExtImm(D_ExtImm), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_ExtImm(E_ExtImm), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_valid(E_valid)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cmp_all(input string tag, input e_t e);
    cmp({tag, ".pc"},    E_PC,            e.pc);
    cmp({tag, ".instr"}, E_Instr,         e.instr);
    cmp({tag, ".rd1"},   E_RD1,           e.rd1);
    cmp({tag, ".rd2"},   E_RD2,           e.rd2);
    cmp({tag, ".imm"},   E_ExtImm,        e.imm);
    cmp({tag, ".a3"},    32'(E_A3),       32'(e.a3));
    cmp({tag, ".tnew"},  32'(E_Tnew),     32'(e.tnew));
    cmp({tag, ".valid"}, 32'(E_valid),    32'(e.valid));
  endtask

  // Monitor: each rising edge presents one E-stage result
  int vec_no = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_t e;
        e = exp_q.pop_front();
        cmp_all($sformatf("vec%0d", vec_no), e);
        vec_no++;
      end
    end
  end

  // Drive one D-stage cycle and push the hand-computed E contents after the edge
  task automatic step(input logic st, input logic fl, input logic hd,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [4:0] a3,
                      input logic [1:0] tn, input e_t e);
    @(negedge clk);
    stall_D = st; flush_D = fl; hold_E = hd;
    D_PC = pc; D_Instr = ins; D_RD1 = r1; D_RD2 = r2;
    D_ExtImm = im; D_A3 = a3; D_Tnew = tn;
    exp_q.push_back(e);
  endtask

  function automatic e_t mk(input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] im, input logic [4:0] a3,
                            input logic [1:0] tn, input logic v);
    e_t e;
    e.pc = pc; e.instr = ins; e.rd1 = r1; e.rd2 = r2;
    e.imm = im; e.a3 = a3; e.tnew = tn; e.valid = v;
    return e;
  endfunction

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
  endtask

  e_t held;

  initial begin
    reset = 1'b1;
    stall_D = 0; flush_D = 0; hold_E = 0;
    D_PC = 0; D_Instr = 0; D_RD1 = 0; D_RD2 = 0; D_ExtImm = 0; D_A3 = 0; D_Tnew = 0;
    #3;
    cmp_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Capture: Tnew 1 -> 0 in E
    step(0, 0, 0, 32'h3000, 32'h2408_0005, 32'h11, 32'h22, 32'h5, 5'd8, 2'd1,
         mk(32'h3000, 32'h2408_0005, 32'h11, 32'h22, 32'h5, 5'd8, 2'd0, 1));
    // Stall: bubble, PC kept
    step(1, 0, 0, 32'h3004, 32'h2529_0001, 32'h33, 32'h44, 32'h1, 5'd9, 2'd2,
         mk(32'h3004, 0, 0, 0, 0, 0, 2'd0, 0));
    // Load-like capture: Tnew 2 -> 1
    held = mk(32'h3008, 32'h8c0a_0000, 32'h55, 32'h66, 32'h0, 5'd10, 2'd1, 1);
    step(0, 0, 0, 32'h3008, 32'h8c0a_0000, 32'h55, 32'h66, 32'h0, 5'd10, 2'd2, held);
    // Hold 3 cycles with toggling inputs, including stall and flush
    step(0, 0, 1, 32'hdead_0000, 32'hffff_ffff, 32'h1, 32'h2, 32'h3, 5'd31, 2'd3, held);
    step(1, 0, 1, 32'hdead_0004, 32'h1234_5678, 32'h4, 32'h5, 32'h6, 5'd1, 2'd2, held);
    step(0, 1, 1, 32'hdead_0008, 32'h8765_4321, 32'h7, 32'h8, 32'h9, 5'd2, 2'd0, held);
    // Release: capture resumes, Tnew 0 stays 0
    step(0, 0, 0, 32'h300c, 32'h0000_0020, 32'h77, 32'h88, 32'h0, 5'd11, 2'd0,
         mk(32'h300c, 32'h0000_0020, 32'h77, 32'h88, 32'h0, 5'd11, 2'd0, 1));
    // Max Tnew 3 -> 2
    step(0, 0, 0, 32'h3010, 32'h3c0c_1234, 32'h99, 32'haa, 32'h1234_0000, 5'd12, 2'd3,
         mk(32'h3010, 32'h3c0c_1234, 32'h99, 32'haa, 32'h1234_0000, 5'd12, 2'd2, 1));
    // $0 destination: Tnew forced to 0, still a real instruction
    step(0, 0, 0, 32'h3014, 32'h8c00_0004, 32'hbb, 32'hcc, 32'h4, 5'd0, 2'd2,
         mk(32'h3014, 32'h8c00_0004, 32'hbb, 32'hcc, 32'h4, 5'd0, 2'd0, 1));
    // Stall + flush together: one bubble
    step(1, 1, 0, 32'h3018, 32'h2402_000a, 32'hdd, 32'hee, 32'ha, 5'd2, 2'd1,
         mk(32'h3018, 0, 0, 0, 0, 0, 2'd0, 0));
    // Flush alone
    step(0, 1, 0, 32'h301c, 32'h2403_000b, 32'hde, 32'hef, 32'hb, 5'd3, 2'd1,
         mk(32'h301c, 0, 0, 0, 0, 0, 2'd0, 0));
    // Capture to $31 with max Tnew
    step(0, 0, 0, 32'h3020, 32'h0c00_0c10, 32'h1111, 32'h2222, 32'hffff_fff0, 5'd31, 2'd3,
         mk(32'h3020, 32'h0c00_0c10, 32'h1111, 32'h2222, 32'hffff_fff0, 5'd31, 2'd2, 1));
    drain();

    // Reset mid-run between edges clears outputs immediately
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    cmp_all("midreset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 32'h3024, 32'h2404_0001, 32'h5, 32'h6, 32'h1, 5'd4, 2'd1,
         mk(32'h3024, 32'h2404_0001, 32'h5, 32'h6, 32'h1, 5'd4, 2'd0, 1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
